gray_decoder: RTL and testbench

- Receive-side companion to the Gray-code counter.
- Samples a Gray-coded count bus and converts it to binary.
- Checks that each new sample is a legal single-step advance, flags wrap-around (the counterpart of the counter's Overflow), and latches a sticky error on any illegal transition.
- Sits downstream of the counter, e.g. after a clock-domain crossing, as decoder plus integrity monitor.

---
 rtl/gray_decoder_if.sv | 33 +++
 rtl/gray_decoder.sv | 132 +++++++++++++
 tb/tb_gray_decoder.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/gray_decoder_if.sv
// Gray decoder sample/result bundle. Dir exists only when GRAY_DEC_BIDIR_EN is defined.
interface gray_decoder_if #(
    parameter int unsigned WIDTH     = 3,
    parameter int unsigned CNT_WIDTH = 8
) ();
    logic                 Valid;
    logic [WIDTH-1:0]     In;
    logic [WIDTH-1:0]     Binary;
    logic                 Step;
    logic                 Wrap;
    logic [CNT_WIDTH-1:0] WrapCount;
    logic                 Error;
    logic                 Synced;
`ifdef GRAY_DEC_BIDIR_EN
    logic                 Dir;
`endif

    modport master (
        output Valid, In,
        input  Binary, Step, Wrap, WrapCount, Error, Synced
`ifdef GRAY_DEC_BIDIR_EN
        , input Dir
`endif
    );

    modport slave (
        input  Valid, In,
        output Binary, Step, Wrap, WrapCount, Error, Synced
`ifdef GRAY_DEC_BIDIR_EN
        , output Dir
`endif
    );
endinterface

// File: rtl/gray_decoder.sv
// Gray-to-binary decoder with single-step integrity monitor and wrap counter.
// Define GRAY_DEC_BIDIR_EN to accept -1 steps and expose the Dir output.
module gray_decoder #(
    parameter int unsigned WIDTH     = 3,
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic           Clk,
    input  logic           Reset,
    gray_decoder_if.slave  bus
);
    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        TRACK = 2'd1,
        ERR   = 2'd2
    } state_e;

    state_e               state_q;
    logic [WIDTH-1:0]     bin_d;
    logic [WIDTH-1:0]     prev_q;
    logic [WIDTH-1:0]     binary_q;
    logic [WIDTH-1:0]     prev_inc;
    logic                 step_q;
    logic                 wrap_q;
    logic [CNT_WIDTH-1:0] wrap_cnt_q;
    logic                 error_q;
    logic                 synced_q;
    logic                 wrap_up;
`ifdef GRAY_DEC_BIDIR_EN
    logic [WIDTH-1:0]     prev_dec;
    logic                 wrap_dn;
    logic                 dir_q;
`endif

    // Binary bit i is the XOR of Gray bits WIDTH-1..i, built as XOR of right shifts.
    always_comb begin
        bin_d = bus.In;
        for (int unsigned k = 1; k < WIDTH; k++) begin
            bin_d = bin_d ^ (bus.In >> k);
        end
    end

    always_comb begin
        prev_inc = prev_q + 1'b1;
        wrap_up  = (prev_q == '1) && (bin_d == '0);
    end

`ifdef GRAY_DEC_BIDIR_EN
    always_comb begin
        prev_dec = prev_q - 1'b1;
        wrap_dn  = (prev_q == '0) && (bin_d == '1);
    end
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= SYNC;
            prev_q     <= '0;
            binary_q   <= '0;
            step_q     <= 1'b0;
            wrap_q     <= 1'b0;
            wrap_cnt_q <= '0;
            error_q    <= 1'b0;
            synced_q   <= 1'b0;
`ifdef GRAY_DEC_BIDIR_EN
            dir_q      <= 1'b0;
`endif
        end else begin
            step_q <= 1'b0;
            wrap_q <= 1'b0;
            if (bus.Valid) begin
                case (state_q)
                    SYNC: begin
                        binary_q <= bin_d;
                        prev_q   <= bin_d;
                        synced_q <= 1'b1;
                        state_q  <= TRACK;
                    end
                    TRACK: begin
                        // An unchanged sample is a stalled counter and is ignored.
                        if (bin_d != prev_q) begin
                            binary_q <= bin_d;
                            prev_q   <= bin_d;
                            if (bin_d == prev_inc) begin
                                step_q <= 1'b1;
`ifdef GRAY_DEC_BIDIR_EN
                                dir_q  <= 1'b1;
`endif
                                if (wrap_up) begin
                                    wrap_q <= 1'b1;
                                    if (wrap_cnt_q != '1) begin
                                        wrap_cnt_q <= wrap_cnt_q + 1'b1;
                                    end
                                end
`ifdef GRAY_DEC_BIDIR_EN
                            end else if (bin_d == prev_dec) begin
                                step_q <= 1'b1;
                                dir_q  <= 1'b0;
                                if (wrap_dn) begin
                                    wrap_q <= 1'b1;
                                    if (wrap_cnt_q != '1) begin
                                        wrap_cnt_q <= wrap_cnt_q + 1'b1;
                                    end
                                end
`endif
                            end else begin
                                error_q <= 1'b1;
                                state_q <= ERR;
                            end
                        end
                    end
                    ERR: begin
                        binary_q <= bin_d;
                        prev_q   <= bin_d;
                    end
                    default: begin
                        state_q <= SYNC;
                    end
                endcase
            end
        end
    end

    assign bus.Binary    = binary_q;
    assign bus.Step      = step_q;
    assign bus.Wrap      = wrap_q;
    assign bus.WrapCount = wrap_cnt_q;
    assign bus.Error     = error_q;
    assign bus.Synced    = synced_q;
`ifdef GRAY_DEC_BIDIR_EN
    assign bus.Dir       = dir_q;
`endif
endmodule

// File: tb/tb_gray_decoder.sv
// Self-checking bench for gray_decoder: directed test plan plus randomized stream vs. a reference model.
module tb_gray_decoder;
    localparam int W    = 3;
    localparam int CW   = 3;
    localparam int N    = 1 << W;
    localparam int CMAX = (1 << CW) - 1;

    logic Clk = 1'b0;
    logic Reset;

    gray_decoder_if #(.WIDTH(W), .CNT_WIDTH(CW)) bus ();

    gray_decoder #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_bin, m_prev, m_cnt;
    bit m_sync, m_err, m_step, m_wrap, m_dir;
    int step_seen;

    function automatic int enc(input int b);
        return (b ^ (b >> 1)) & (N - 1);
    endfunction

    // Decode by searching the code table rather than by bitwise formula.
    function automatic int dec(input int g);
        for (int b = 0; b < N; b++) begin
            if (enc(b) == g) return b;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model(input bit r, input bit v, input int g);
        int b;
        m_step = 0;
        m_wrap = 0;
        if (r) begin
            m_bin = 0; m_prev = 0; m_cnt = 0;
            m_sync = 0; m_err = 0; m_dir = 0;
        end else if (v) begin
            b = dec(g);
            if (!m_sync) begin
                m_bin = b; m_prev = b; m_sync = 1;
            end else if (m_err) begin
                m_bin = b; m_prev = b;
            end else if (b == m_prev) begin
                // stall: nothing changes
            end else if (b == (m_prev + 1) % N) begin
                m_step = 1; m_dir = 1;
                if (b == 0) begin
                    m_wrap = 1;
                    if (m_cnt < CMAX) m_cnt++;
                end
                m_bin = b; m_prev = b;
`ifdef GRAY_DEC_BIDIR_EN
            end else if (b == (m_prev + N - 1) % N) begin
                m_step = 1; m_dir = 0;
                if (b == N - 1) begin
                    m_wrap = 1;
                    if (m_cnt < CMAX) m_cnt++;
                end
                m_bin = b; m_prev = b;
`endif
            end else begin
                m_err = 1; m_bin = b; m_prev = b;
            end
        end
    endtask

    task automatic tick(input bit r, input bit v, input int g, input string tag);
        logic [W-1:0] gv;
        gv = g[W-1:0];
        Reset = r;
        bus.Valid = v;
        bus.In = gv;
        @(posedge Clk);
        model(r, v, g);
        #1;
        if (bus.Step === 1'b1) step_seen++;
        chk({tag, ".Binary"},    32'(bus.Binary),    32'(m_bin));
        chk({tag, ".Step"},      32'(bus.Step),      32'(m_step));
        chk({tag, ".Wrap"},      32'(bus.Wrap),      32'(m_wrap));
        chk({tag, ".WrapCount"}, 32'(bus.WrapCount), 32'(m_cnt));
        chk({tag, ".Error"},     32'(bus.Error),     32'(m_err));
        chk({tag, ".Synced"},    32'(bus.Synced),    32'(m_sync));
`ifdef GRAY_DEC_BIDIR_EN
        chk({tag, ".Dir"},       32'(bus.Dir),       32'(m_dir));
`endif
    endtask

    int seq[9] = '{0, 1, 2, 3, 4, 5, 6, 7, 0};

    initial begin
        int b, k, g;
        bit r, v;
        Reset = 1'b1;
        bus.Valid = 1'b0;
        bus.In = '0;

        // Reset state
        tick(1, 0, 0, "reset");
        chk("reset.Binary0", 32'(bus.Binary), 32'd0);
        chk("reset.Synced0", 32'(bus.Synced), 32'd0);

        // Full up-count with wrap
        step_seen = 0;
        for (int i = 0; i < 9; i++) tick(0, 1, enc(seq[i]), "upseq");
        chk("upseq.steps", 32'(step_seen), 32'd8);
        chk("upseq.wrapcnt", 32'(bus.WrapCount), 32'd1);
        chk("upseq.bin", 32'(bus.Binary), 32'd0);

        // Same sequence with Valid toggling
        tick(1, 0, 0, "rst2");
        step_seen = 0;
        for (int i = 0; i < 9; i++) begin
            tick(0, 1, enc(seq[i]), "tog.v");
            tick(0, 0, enc(seq[(i + 3) % 9]), "tog.nv");
        end
        chk("tog.steps", 32'(step_seen), 32'd8);
        chk("tog.wrapcnt", 32'(bus.WrapCount), 32'd1);

        // Stalled counter at 011
        tick(1, 0, 0, "rst3");
        for (int i = 0; i < 5; i++) tick(0, 1, 3'b011, "stall");
        chk("stall.bin", 32'(bus.Binary), 32'd2);

        // Skip from 1 to 3
        tick(1, 0, 0, "rst4");
        tick(0, 1, 3'b001, "skip.sync");
        tick(0, 1, 3'b010, "skip.bad");
        chk("skip.err", 32'(bus.Error), 32'd1);
        tick(0, 1, 3'b110, "skip.trk");
        tick(0, 1, 3'b111, "skip.trk");
        chk("skip.bin", 32'(bus.Binary), 32'd5);

        // Down-step 0 -> 7
        tick(1, 0, 0, "rst5");
        tick(0, 1, 3'b000, "down.sync");
        tick(0, 1, 3'b100, "down.step");
`ifdef GRAY_DEC_BIDIR_EN
        chk("down.err", 32'(bus.Error), 32'd0);
        chk("down.wrap", 32'(bus.Wrap), 32'd1);
`else
        chk("down.err", 32'(bus.Error), 32'd1);
`endif

        // Mid-stream reset with Binary=5 and Error=1
        tick(1, 0, 0, "rst6");
        tick(0, 1, enc(3), "mid.sync");
        tick(0, 1, enc(5), "mid.bad");
        chk("mid.bin5", 32'(bus.Binary), 32'd5);
        tick(1, 1, enc(6), "mid.rst");
        chk("mid.rstErr", 32'(bus.Error), 32'd0);
        tick(0, 1, 3'b110, "mid.resync");
        chk("mid.bin4", 32'(bus.Binary), 32'd4);

        // Wrap counter saturation
        tick(1, 0, 0, "rst7");
        tick(0, 1, 0, "sat.sync");
        for (int i = 1; i <= N * (CMAX + 2); i++) tick(0, 1, enc(i % N), "sat");
        chk("sat.cnt", 32'(bus.WrapCount), 32'(CMAX));

        // Randomized stream
        tick(1, 0, 0, "rst8");
        for (int i = 0; i < 1500; i++) begin
            r = ($urandom_range(0, 99) == 0);
            v = ($urandom_range(0, 3) != 0);
            k = $urandom_range(0, 19);
            if (k < 14)       b = (m_prev + 1) % N;
            else if (k < 16)  b = m_prev;
            else if (k < 18)  b = (m_prev + N - 1) % N;
            else              b = $urandom_range(0, N - 1);
            g = enc(b);
            if (!r && $urandom_range(0, 49) == 0) tick(1, 0, 0, "rnd.rst");
            else tick(r, v, g, "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
